// File: rtl/axis_output_packer.sv
// axis_output_packer: packs PACK_FACTOR narrow words per wide AXI-Stream beat with tkeep/tlast framing.
// Optional AXIS_OUTPUT_PACKER_FLUSH_EN adds a flush input that closes the current partial frame.
module axis_output_packer #(
  parameter int IN_WIDTH    = 32,
  parameter int PACK_FACTOR = 4,
  parameter int FRAME_WORDS = 128,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
`ifdef AXIS_OUTPUT_PACKER_FLUSH_EN
  input  logic                            flush,
`endif
  input  logic [IN_WIDTH-1:0]             s_axis_input_tdata,
  input  logic                            s_axis_input_tvalid,
  output logic                            s_axis_input_tready,
  output logic [IN_WIDTH*PACK_FACTOR-1:0] m_axis_output_tdata,
  output logic [PACK_FACTOR-1:0]          m_axis_output_tkeep,
  output logic                            m_axis_output_tlast,
  output logic                            m_axis_output_tvalid,
  input  logic                            m_axis_output_tready,
  output logic [CNT_WIDTH-1:0]            frame_count
);
  localparam int WI = $clog2(PACK_FACTOR);
  localparam int FI = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
  logic [WI-1:0] word_idx;
  logic [FI-1:0] frame_idx;
  logic [IN_WIDTH*PACK_FACTOR-1:0] pack_data, next_data;
  logic [PACK_FACTOR-1:0] pack_keep, next_keep;
  logic last_word, completing, out_free, accept, load, flush_go;
  assign last_word  = frame_idx == FI'(FRAME_WORDS - 1);
  assign completing = word_idx == WI'(PACK_FACTOR - 1) || last_word;
  assign out_free   = !m_axis_output_tvalid || m_axis_output_tready;
`ifdef AXIS_OUTPUT_PACKER_FLUSH_EN
  logic flush_pend;
  assign s_axis_input_tready = (out_free || !completing) && !flush_pend;
  assign flush_go = (flush || flush_pend) && |next_keep && out_free;
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) flush_pend <= 1'b0;
    else if (flush_go) flush_pend <= 1'b0;
    else if (flush && |next_keep) flush_pend <= 1'b1;
`else
  assign s_axis_input_tready = out_free || !completing;
  assign flush_go = 1'b0;
`endif
  assign accept = s_axis_input_tvalid && s_axis_input_tready;
  assign load   = (accept && completing) || flush_go;
  // Merge the word being accepted this cycle so a completing word lands in the same beat
  always_comb begin
    next_data = pack_data;
    next_keep = pack_keep;
    for (int i = 0; i < PACK_FACTOR; i++)
      if (accept && word_idx == WI'(i)) begin
        next_data[i*IN_WIDTH +: IN_WIDTH] = s_axis_input_tdata;
        next_keep[i] = 1'b1;
      end
  end
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      word_idx  <= '0;
      frame_idx <= '0;
      pack_data <= '0;
      pack_keep <= '0;
    end else begin
      if (flush_go) begin
        word_idx  <= '0;
        frame_idx <= '0;
      end else if (accept) begin
        word_idx  <= completing ? '0 : word_idx + 1'b1;
        frame_idx <= last_word ? '0 : frame_idx + 1'b1;
      end
      pack_data <= load ? '0 : next_data;
      pack_keep <= load ? '0 : next_keep;
    end
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      m_axis_output_tdata  <= '0;
      m_axis_output_tkeep  <= '0;
      m_axis_output_tlast  <= 1'b0;
      m_axis_output_tvalid <= 1'b0;
    end else if (load) begin
      m_axis_output_tdata  <= next_data;
      m_axis_output_tkeep  <= next_keep;
      m_axis_output_tlast  <= last_word || flush_go;
      m_axis_output_tvalid <= 1'b1;
    end else if (m_axis_output_tready) begin
      m_axis_output_tvalid <= 1'b0;
    end
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) frame_count <= '0;
    else if (m_axis_output_tvalid && m_axis_output_tready && m_axis_output_tlast)
      frame_count <= frame_count + 1'b1;
endmodule

// File: doc/axis_output_packer.md
Name: axis_output_packer

Overview:
- Downstream stage of the multi-engine processing top; consumes its narrow output stream (one ENGINE_WIDTH word per beat).
- Packs PACK_FACTOR consecutive words into one wide AXI-Stream beat with word-granular tkeep.
- Marks frame boundaries with tlast every FRAME_WORDS input words, emitting a partial final beat when FRAME_WORDS is not a multiple of PACK_FACTOR.
- Sits between the processing top and the wide DMA/memory write path.

Parameters:
- IN_WIDTH, 32, width of one input word.
- PACK_FACTOR, 4, input words per output beat; power of two, ≥2.
- FRAME_WORDS, 128, input words per frame; ≥1, any value.
- CNT_WIDTH, 16, width of the frame_count status counter.

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- s_axis_input_tdata  in  IN_WIDTH  input word.
- s_axis_input_tvalid  in  1  input valid.
- s_axis_input_tready  out  1  input ready.
- m_axis_output_tdata  out  IN_WIDTH*PACK_FACTOR  packed beat; word 0 in LSBs.
- m_axis_output_tkeep  out  PACK_FACTOR  bit i set when word i is valid.
- m_axis_output_tlast  out  1  last beat of a frame.
- m_axis_output_tvalid  out  1  output valid.
- m_axis_output_tready  in  1  output ready.
- frame_count  out  CNT_WIDTH  number of frames fully emitted; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Interface: one clock (ap_clk); reset is asynchronous and active-high (ap_rst).
- Reset (asynchronous, takes effect immediately, including mid-beat or mid-frame):
  - word_idx=0, frame_idx=0, pack register=0, pack keep=0.
  - Output register cleared: tvalid=0, tdata=0, tkeep=0, tlast=0.
  - frame_count=0.
  - Partially packed data is discarded; the first word after reset starts a new beat and a new frame.
- Input acceptance: a word is accepted when s_tvalid && s_tready. It is written into pack slot word_idx and sets keep bit word_idx.
- A "completing" word is one with word_idx==PACK_FACTOR-1 or frame_idx==FRAME_WORDS-1.
- s_tready = !out_valid || m_tready || !completing(word_idx, frame_idx).
  - Independent of s_tvalid; depends combinationally on m_tready only.
- On acceptance of a completing word, the next edge:
  - loads the output register with the packed data including the new word;
  - sets tkeep to the accumulated keep;
  - sets tlast=(frame_idx==FRAME_WORDS-1) and tvalid=1;
  - clears the pack register and keep to 0.
- Unused words in a partial beat are zero.
- Latency: completing word accepted at edge N → beat visible after edge N (one register stage).
- Throughput: one input word per cycle sustained while downstream is ready.
- Counters:
  - word_idx increments per accepted word and returns to 0 after a completing word.
  - frame_idx increments per accepted word and wraps to 0 after FRAME_WORDS-1.
  - Both wrap with no gap cycle.
- Output handshake:
  - tvalid, once asserted, holds with tdata/tkeep/tlast stable until m_tready.
  - On m_tready with no new beat loading, tvalid returns to 0 next edge.
  - A simultaneous drain and load in the same cycle gives back-to-back beats with no bubble.
- frame_count increments on the output handshake of a beat with tlast=1. It does not increment at load time.
- Stall: while out_valid && !m_tready, non-completing words are still accepted into the pack register. Only the completing word is back-pressured.
- Edge cases:
  - FRAME_WORDS=1: every beat carries tkeep=1 and tlast=1.
  - FRAME_WORDS < PACK_FACTOR: every beat is partial.

Optional Feature:
- Macro: AXIS_OUTPUT_PACKER_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - A flush pulse with pack keep≠0 forces emission of the current partial beat with tlast=1 once the output register is free. Until then s_tready=0.
  - frame_idx and word_idx then reset to 0.
  - flush with keep=0 is ignored.
  - flush concurrent with an accepted input word: the word is included in the flushed beat.
- Undefined: no flush port; frames end only by FRAME_WORDS count.

Test Plan:
- PACK_FACTOR=4, FRAME_WORDS=8, m_tready=1, words 0x1..0x8 back-to-back → two beats: 0x00000004_00000003_00000002_00000001 tkeep=0xF tlast=0, then 0x8_7_6_5 tkeep=0xF tlast=1; frame_count=1; s_tready constantly 1.
- FRAME_WORDS=10, words 0x1..0xA → third beat tdata=0x0000000A_00000009 in low 64 bits with upper zero, tkeep=0x3, tlast=1; the next frame starts at word 0 of a fresh beat.
- m_tready=0 after first beat, continuous input → words 5,6,7 accepted, word 8 stalls (s_tready=0); beat 1 held stable; releasing m_tready gives beat 2 one cycle after word 8 is accepted.
- Assert ap_rst asynchronously between edges after 2 words of a beat → tvalid, tkeep, tlast and frame_count go 0 immediately; after release, 4 new words give one full beat containing only the new words.
- frame_count wrap with CNT_WIDTH=2 and FRAME_WORDS=1 → 5 frames drained gives frame_count sequence 1,2,3,0,1.
- With AXIS_OUTPUT_PACKER_FLUSH_EN, FRAME_WORDS=8: 3 words then flush → beat tkeep=0x7 tlast=1; the next 8 words form a complete frame with tlast on the second beat.
